rob_committer: RTL and testbench
================================

Name: rob_committer

Overview:
- Parametrised in-order commit stage that generalises the single-instruction writeback committer into a reorder buffer of DEPTH entries fed by NUM_FU out-of-order result channels.
- Dispatcher allocates an entry per instruction in program order; functional units return tagged results in any order.
- Block retires the head entry to the register file and redirects the PC generator, flushing younger entries on a taken branch or CSR update.

Parameters:
- XLEN, 32, data/PC width
- DEPTH, 8, ROB entries; power of two, >=2
- NUM_FU, 3, result channels (ALU, BRU, SYS order by convention)
- TAG_W, $clog2(DEPTH), entry tag width (derived; do not override)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_valid  in  1  dispatcher allocation request
- alloc_ready  out  1  entry available
- alloc_rd  in  5  destination register (0 = no write)
- alloc_pc  in  XLEN  instruction PC
- alloc_tag  out  TAG_W  tag assigned to the current allocation (= tail index)
- res_valid  in  NUM_FU  per-channel result valid
- res_ready  out  NUM_FU  always all ones outside reset
- res_tag  in  NUM_FU*TAG_W  per-channel entry tag
- res_data  in  NUM_FU*XLEN  per-channel result
- res_redirect  in  NUM_FU  result requires PC redirect
- res_new_pc  in  NUM_FU*XLEN  redirect target
- wbrf_valid  out  1  commit to register file
- wbrf_ready  in  1
- wbrf_rd  out  5
- wbrf_wdata  out  XLEN
- wbrf_pc  out  XLEN  committing instruction PC
- wbpcg_valid  out  1  redirect to PC generator
- wbpcg_ready  in  1
- wbpcg_pc  out  XLEN  redirect target
- flush  out  1  younger entries discarded this cycle
- occupancy  out  TAG_W+1  valid entry count

Behaviour:
- Reset (synchronous, active-high): all entries invalid; head = tail = 0 including wrap bits; occupancy 0.
  - Visible after the reset edge: alloc_ready 1, wbrf_valid 0, wbpcg_valid 0, flush 0, res_ready all 1.
  - Reset mid-operation discards all in-flight entries with no commit.
- Pointers: head and tail are TAG_W+1 bits; the extra bit is the wrap bit.
  - Empty: head == tail.
  - Full: index bits equal and wrap bits differ.
  - Both pointers increment modulo 2^(TAG_W+1).
- Allocation:
  - alloc_ready = !full && !commit_redirect; alloc_tag = tail[TAG_W-1:0].
  - On alloc_valid && alloc_ready, the entry is written {valid=1, done=0, rd, pc} and tail increments.
- Results:
  - Each res_valid[i] writes data, redirect and new_pc into entry res_tag[i] and sets done at the next edge.
  - A result targeting an invalid entry (flushed or never allocated) is ignored.
  - Two channels with the same tag in one cycle is illegal; the lowest index wins and an assertion fires.
- Commit: head entry valid && done.
  - wbrf_valid = head_done && (!redirect || wbpcg_ready).
  - wbpcg_valid = head_done && redirect && wbrf_ready.
  - Fire occurs when wbrf_valid && wbrf_ready (redirect entries require both readies).
  - On fire: entry invalidated; head increments.
- Redirect commit:
  - flush = 1 in the fire cycle.
  - Every entry except the committing one is invalidated and tail <= head+1, so the ROB is empty next cycle.
  - Allocation is blocked that cycle.
  - Results arriving that cycle are dropped.
- Latency: result-to-commit minimum 1 cycle; one commit per cycle maximum.
- Simultaneous allocation and non-redirect commit in one cycle: both apply; occupancy unchanged.
- occupancy is registered and equals tail - head.

Optional Feature:
- ROB_HEAD_BYPASS_EN defined:
  - A res_valid[i] whose tag equals the valid, not-done head entry is forwarded combinationally.
  - That entry commits in the same cycle using res_data/res_redirect/res_new_pc; result-to-commit latency is 0.
  - The entry's done bit is still written, so a stalled commit retries next cycle.
- Undefined: no bypass path; latency 1 as above.

Test Plan:
- Reset, allocate 3 (tags 0,1,2), return results in order 2,0,1 with data 0x30,0x10,0x20 -> wbrf commits rd/data for tags 0,1,2 in consecutive cycles, data 0x10,0x20,0x30.
- Allocate DEPTH=8 entries without results -> alloc_ready 0, occupancy 8; a 9th alloc_valid is not accepted; the first commit restores alloc_ready next cycle.
- Allocate 4; tag 1 returns redirect new_pc 0x200 after tag 0 commits -> wbpcg_valid, wbpcg_pc 0x200, flush pulse 1 cycle; tags 2,3 never commit; occupancy 0 next cycle; next alloc_tag = 2.
- Redirect head with wbrf_ready=1, wbpcg_ready=0 for 3 cycles -> no commit and no flush until wbpcg_ready=1, then a single commit.
- Wrap: run 20 alloc/commit pairs with DEPTH=8 -> tags cycle 0..7 repeatedly; full/empty flags correct across wrap; no lost commits.
- With ROB_HEAD_BYPASS_EN: result for the empty-done head arrives at cycle N -> wbrf_valid in cycle N; without the macro -> cycle N+1.

Source files
------------

// File: rtl/rob_committer.sv
// In-order commit stage: DEPTH-entry reorder buffer fed by NUM_FU tagged, out-of-order result channels.
// Optional macro ROB_HEAD_BYPASS_EN forwards a result for the pending head straight into commit.
module rob_committer #(
    parameter int  XLEN   = 32,
    parameter int  DEPTH  = 8,
    parameter int  NUM_FU = 3,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [4:0]               alloc_rd,
    input  logic [XLEN-1:0]          alloc_pc,
    output logic [TAG_W-1:0]         alloc_tag,
    input  logic [NUM_FU-1:0]        res_valid,
    output logic [NUM_FU-1:0]        res_ready,
    input  logic [NUM_FU*TAG_W-1:0]  res_tag,
    input  logic [NUM_FU*XLEN-1:0]   res_data,
    input  logic [NUM_FU-1:0]        res_redirect,
    input  logic [NUM_FU*XLEN-1:0]   res_new_pc,
    output logic                     wbrf_valid,
    input  logic                     wbrf_ready,
    output logic [4:0]               wbrf_rd,
    output logic [XLEN-1:0]          wbrf_wdata,
    output logic [XLEN-1:0]          wbrf_pc,
    output logic                     wbpcg_valid,
    input  logic                     wbpcg_ready,
    output logic [XLEN-1:0]          wbpcg_pc,
    output logic                     flush,
    output logic [TAG_W:0]           occupancy
);
    localparam int PTR_W = TAG_W + 1;

    // Pointers carry one wrap bit above the index so full and empty are distinguishable.
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] occupancy_q, occupancy_d;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] redirect_q, redirect_d;
    logic [4:0]       rd_q     [DEPTH];
    logic [4:0]       rd_d     [DEPTH];
    logic [XLEN-1:0]  pc_q     [DEPTH];
    logic [XLEN-1:0]  pc_d     [DEPTH];
    logic [XLEN-1:0]  data_q   [DEPTH];
    logic [XLEN-1:0]  data_d   [DEPTH];
    logic [XLEN-1:0]  new_pc_q [DEPTH];
    logic [XLEN-1:0]  new_pc_d [DEPTH];

    logic [TAG_W-1:0] res_tag_w    [NUM_FU];
    logic [XLEN-1:0]  res_data_w   [NUM_FU];
    logic [XLEN-1:0]  res_new_pc_w [NUM_FU];

    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic             full;
    logic             head_done;
    logic             head_redirect;
    logic [XLEN-1:0]  head_data;
    logic [XLEN-1:0]  head_new_pc;
    logic             fire;
    logic             commit_redirect;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            res_tag_w[i]    = res_tag[i*TAG_W +: TAG_W];
            res_data_w[i]   = res_data[i*XLEN +: XLEN];
            res_new_pc_w[i] = res_new_pc[i*XLEN +: XLEN];
        end
    end

    // Handshakes: a transfer happens on a cycle where both valid and ready are high; a redirect
    // commit needs wbrf_ready and wbpcg_ready together so the two sinks always see it as one event.
    always_comb begin
        head_idx      = head_q[TAG_W-1:0];
        tail_idx      = tail_q[TAG_W-1:0];
        full          = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
        head_done     = valid_q[head_idx] && done_q[head_idx];
        head_redirect = redirect_q[head_idx];
        head_data     = data_q[head_idx];
        head_new_pc   = new_pc_q[head_idx];
`ifdef ROB_HEAD_BYPASS_EN
        // Descending scan so the lowest-numbered matching channel is the one forwarded.
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (valid_q[head_idx] && !done_q[head_idx] && res_valid[i] &&
                (res_tag_w[i] == head_idx)) begin
                head_done     = 1'b1;
                head_redirect = res_redirect[i];
                head_data     = res_data_w[i];
                head_new_pc   = res_new_pc_w[i];
            end
        end
`endif
        wbrf_valid      = head_done && (!head_redirect || wbpcg_ready);
        wbpcg_valid     = head_done && head_redirect && wbrf_ready;
        fire            = wbrf_valid && wbrf_ready;
        commit_redirect = fire && head_redirect;
    end

    assign wbrf_rd    = rd_q[head_idx];
    assign wbrf_pc    = pc_q[head_idx];
    assign wbrf_wdata = head_data;
    assign wbpcg_pc   = head_new_pc;
    assign res_ready  = {NUM_FU{~rst}};
    assign occupancy  = occupancy_q;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        valid_d     = valid_q;
        done_d      = done_q;
        redirect_d  = redirect_q;
        rd_d        = rd_q;
        pc_d        = pc_q;
        data_d      = data_q;
        new_pc_d    = new_pc_q;
        alloc_ready = !full && !commit_redirect;
        alloc_tag   = tail_idx;
        flush       = commit_redirect;

        if (!commit_redirect) begin
            for (int i = NUM_FU - 1; i >= 0; i--) begin
                if (res_valid[i] && valid_q[res_tag_w[i]]) begin
                    done_d[res_tag_w[i]]     = 1'b1;
                    redirect_d[res_tag_w[i]] = res_redirect[i];
                    data_d[res_tag_w[i]]     = res_data_w[i];
                    new_pc_d[res_tag_w[i]]   = res_new_pc_w[i];
                end
            end
        end

        if (fire) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_W'(1);
            if (commit_redirect) begin
                valid_d = '0;
                tail_d  = head_q + PTR_W'(1);
            end
        end

        if (alloc_valid && alloc_ready) begin
            valid_d[tail_idx]    = 1'b1;
            done_d[tail_idx]     = 1'b0;
            redirect_d[tail_idx] = 1'b0;
            rd_d[tail_idx]       = alloc_rd;
            pc_d[tail_idx]       = alloc_pc;
            tail_d               = tail_q + PTR_W'(1);
        end

        occupancy_d = tail_d - head_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            occupancy_q <= '0;
            valid_q     <= '0;
            done_q      <= '0;
            redirect_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            occupancy_q <= occupancy_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            redirect_q  <= redirect_d;
        end
    end

    // Payload needs no reset: it is only observed through a valid entry.
    always_ff @(posedge clk) begin
        rd_q     <= rd_d;
        pc_q     <= pc_d;
        data_q   <= data_d;
        new_pc_q <= new_pc_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                for (int j = i + 1; j < NUM_FU; j++) begin
                    assert (!(res_valid[i] && res_valid[j] && (res_tag_w[i] == res_tag_w[j])));
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_committer.sv
// Randomised and directed bench for rob_committer against a program-order queue model.
`timescale 1ns/1ps
module tb_rob_committer;
    localparam int XLEN   = 32;
    localparam int DEPTH  = 8;
    localparam int NUM_FU = 3;
    localparam int TAG_W  = $clog2(DEPTH);
`ifdef ROB_HEAD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    alloc_valid;
    logic                    alloc_ready;
    logic [4:0]              alloc_rd;
    logic [XLEN-1:0]         alloc_pc;
    logic [TAG_W-1:0]        alloc_tag;
    logic [NUM_FU-1:0]       res_valid;
    logic [NUM_FU-1:0]       res_ready;
    logic [NUM_FU*TAG_W-1:0] res_tag;
    logic [NUM_FU*XLEN-1:0]  res_data;
    logic [NUM_FU-1:0]       res_redirect;
    logic [NUM_FU*XLEN-1:0]  res_new_pc;
    logic                    wbrf_valid;
    logic                    wbrf_ready;
    logic [4:0]              wbrf_rd;
    logic [XLEN-1:0]         wbrf_wdata;
    logic [XLEN-1:0]         wbrf_pc;
    logic                    wbpcg_valid;
    logic                    wbpcg_ready;
    logic [XLEN-1:0]         wbpcg_pc;
    logic                    flush;
    logic [TAG_W:0]          occupancy;

    always #5 clk = ~clk;

    rob_committer #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_FU(NUM_FU)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
        .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data),
        .res_redirect(res_redirect), .res_new_pc(res_new_pc),
        .wbrf_valid(wbrf_valid), .wbrf_ready(wbrf_ready), .wbrf_rd(wbrf_rd),
        .wbrf_wdata(wbrf_wdata), .wbrf_pc(wbrf_pc),
        .wbpcg_valid(wbpcg_valid), .wbpcg_ready(wbpcg_ready), .wbpcg_pc(wbpcg_pc),
        .flush(flush), .occupancy(occupancy)
    );

    typedef struct {
        int              tag;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        bit              done;
        logic [XLEN-1:0] data;
        bit              redir;
        logic [XLEN-1:0] npc;
    } ent_t;

    ent_t            rob_q[$];
    int              next_tag;
    int              checks;
    int              errors;
    int              cyc;
    int              flush_cnt;
    bit              last_wbrf_valid;
    logic [XLEN-1:0] commit_q[$];
    int              commit_cyc[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        alloc_valid  = 1'b0;
        alloc_rd     = '0;
        alloc_pc     = '0;
        res_valid    = '0;
        res_tag      = '0;
        res_data     = '0;
        res_redirect = '0;
        res_new_pc   = '0;
    endtask

    task automatic set_res(input int ch, input int tag, input logic [XLEN-1:0] data,
                           input bit redir, input logic [XLEN-1:0] npc);
        res_valid[ch]                  = 1'b1;
        res_tag[ch*TAG_W +: TAG_W]     = TAG_W'(tag);
        res_data[ch*XLEN +: XLEN]      = data;
        res_redirect[ch]               = redir;
        res_new_pc[ch*XLEN +: XLEN]    = npc;
    endtask

    task automatic set_alloc(input logic [4:0] rd, input logic [XLEN-1:0] pc);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        alloc_pc    = pc;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rob_q.delete();
        next_tag  = 0;
        flush_cnt = 0;
        commit_q.delete();
        commit_cyc.delete();
    endtask

    // Called at posedge+1 with this cycle's inputs applied; checks, advances the model, returns at next posedge+1.
    task automatic step();
        ent_t            h;
        bit              has, hd, hr, efire, eredir, eready;
        logic [XLEN-1:0] hdata, hnpc;
        has   = rob_q.size() > 0;
        hd    = 1'b0;
        hr    = 1'b0;
        hdata = '0;
        hnpc  = '0;
        if (has) begin
            h     = rob_q[0];
            hd    = h.done;
            hr    = h.redir;
            hdata = h.data;
            hnpc  = h.npc;
            if (BYP && !h.done) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (res_valid[i] && int'(res_tag[i*TAG_W +: TAG_W]) == h.tag) begin
                        hd    = 1'b1;
                        hr    = res_redirect[i];
                        hdata = res_data[i*XLEN +: XLEN];
                        hnpc  = res_new_pc[i*XLEN +: XLEN];
                        break;
                    end
                end
            end
        end
        efire  = hd && wbrf_ready && (!hr || wbpcg_ready);
        eredir = efire && hr;
        eready = (rob_q.size() < DEPTH) && !eredir;

        @(negedge clk);
        check_eq("res_ready", res_ready, {NUM_FU{1'b1}});
        check_eq("occupancy", occupancy, rob_q.size());
        check_eq("alloc_ready", alloc_ready, eready);
        check_eq("alloc_tag", alloc_tag, next_tag);
        check_eq("wbrf_valid", wbrf_valid, hd && (!hr || wbpcg_ready));
        check_eq("wbpcg_valid", wbpcg_valid, hd && hr && wbrf_ready);
        check_eq("flush", flush, eredir);
        if (hd) begin
            check_eq("wbrf_rd", wbrf_rd, h.rd);
            check_eq("wbrf_pc", wbrf_pc, h.pc);
            check_eq("wbrf_wdata", wbrf_wdata, hdata);
            if (hr) check_eq("wbpcg_pc", wbpcg_pc, hnpc);
        end
        last_wbrf_valid = wbrf_valid;
        if (wbrf_valid && wbrf_ready) begin
            commit_q.push_back(wbrf_wdata);
            commit_cyc.push_back(cyc);
        end
        if (flush) flush_cnt++;

        if (!eredir) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (res_valid[i]) begin
                    for (int k = 0; k < rob_q.size(); k++) begin
                        if (rob_q[k].tag == int'(res_tag[i*TAG_W +: TAG_W])) begin
                            rob_q[k].done  = 1'b1;
                            rob_q[k].data  = res_data[i*XLEN +: XLEN];
                            rob_q[k].redir = res_redirect[i];
                            rob_q[k].npc   = res_new_pc[i*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
        if (efire) begin
            if (eredir) begin
                next_tag = (h.tag + 1) % DEPTH;
                rob_q.delete();
            end else begin
                void'(rob_q.pop_front());
            end
        end
        if (alloc_valid && eready) begin
            rob_q.push_back('{tag: next_tag, rd: alloc_rd, pc: alloc_pc, done: 1'b0,
                              data: '0, redir: 1'b0, npc: '0});
            next_tag = (next_tag + 1) % DEPTH;
        end

        @(posedge clk);
        #1;
        cyc++;
        alloc_valid = 1'b0;
        res_valid   = '0;
    endtask

    task automatic random_cycle();
        bit [DEPTH-1:0] used;
        int             t;
        used = '0;
        clear_inputs();
        if ($urandom_range(0, 99) < 60) set_alloc(5'($urandom_range(0, 31)), $urandom);
        for (int ch = 0; ch < NUM_FU; ch++) begin
            if ($urandom_range(0, 99) < 45) begin
                t = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 3) != 0 && rob_q.size() > 0)
                    t = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
                if (!used[t]) begin
                    used[t] = 1'b1;
                    set_res(ch, t, $urandom, $urandom_range(0, 99) < 8, $urandom);
                end
            end
        end
        wbrf_ready  = $urandom_range(0, 99) < 80;
        wbpcg_ready = $urandom_range(0, 99) < 70;
        step();
    endtask

    initial begin
        int fc;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        wbrf_ready  = 1'b1;
        wbpcg_ready = 1'b1;
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        do_reset();

        // In-order commit of out-of-order results.
        for (int k = 0; k < 3; k++) begin
            set_alloc(5'(k + 1), 32'h100 + 32'(4 * k));
            step();
        end
        set_res(0, 2, 32'h30, 1'b0, '0); step();
        set_res(0, 0, 32'h10, 1'b0, '0); step();
        set_res(0, 1, 32'h20, 1'b0, '0); step();
        repeat (3) step();
        check_eq("ooo_count", commit_q.size(), 3);
        if (commit_q.size() == 3) begin
            check_eq("ooo_d0", commit_q[0], 32'h10);
            check_eq("ooo_d1", commit_q[1], 32'h20);
            check_eq("ooo_d2", commit_q[2], 32'h30);
            check_eq("ooo_gap1", commit_cyc[1] - commit_cyc[0], 1);
            check_eq("ooo_gap2", commit_cyc[2] - commit_cyc[1], 1);
        end

        // Fill to DEPTH, reject extra allocation, free one slot.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            set_alloc(5'(k), 32'h400 + 32'(k));
            step();
        end
        check_eq("full_ready", alloc_ready, 1'b0);
        check_eq("full_occ", occupancy, DEPTH);
        set_alloc(5'd9, 32'h999); step();
        check_eq("full_occ_after9", occupancy, DEPTH);
        set_res(1, 0, 32'hAA, 1'b0, '0); step();
        repeat (2) step();
        check_eq("full_reopen", alloc_ready, 1'b1);
        check_eq("full_occ_minus1", occupancy, DEPTH - 1);

        // Taken redirect flushes younger entries.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_alloc(5'(k + 1), 32'h500 + 32'(4 * k));
            step();
        end
        set_res(0, 0, 32'h11, 1'b0, '0); step();
        step();
        set_res(1, 1, 32'h22, 1'b1, 32'h200); step();
        step();
        set_res(0, 2, 32'h33, 1'b0, '0); set_res(2, 3, 32'h44, 1'b0, '0); step();
        repeat (2) step();
        check_eq("redir_flush_once", flush_cnt, 1);
        check_eq("redir_commits", commit_q.size(), 2);
        check_eq("redir_occ", occupancy, 0);
        check_eq("redir_next_tag", alloc_tag, 2);

        // Redirect held off by wbpcg_ready.
        do_reset();
        set_alloc(5'd7, 32'h600); step();
        wbpcg_ready = 1'b0;
        set_res(2, 0, 32'h77, 1'b1, 32'h300); step();
        repeat (2) step();
        check_eq("stall_no_commit", commit_q.size(), 0);
        check_eq("stall_no_flush", flush_cnt, 0);
        wbpcg_ready = 1'b1;
        step();
        check_eq("stall_commit", commit_q.size(), 1);
        check_eq("stall_flush", flush_cnt, 1);
        step();
        check_eq("stall_single", commit_q.size(), 1);

        // Tag wrap over 20 alloc/commit pairs.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            check_eq("wrap_tag", alloc_tag, k % DEPTH);
            set_alloc(5'(k % 32), 32'h700 + 32'(k));
            step();
            set_res(k % NUM_FU, k % DEPTH, 32'(k), 1'b0, '0);
            step();
            step();
        end
        check_eq("wrap_commits", commit_q.size(), 20);
        check_eq("wrap_empty", occupancy, 0);

        // Result-to-commit latency.
        do_reset();
        set_alloc(5'd3, 32'h800); step();
        step();
        set_res(0, 0, 32'h55, 1'b0, '0); step();
        check_eq("lat_same_cycle", last_wbrf_valid, BYP);
        step();
        check_eq("lat_next_cycle", last_wbrf_valid, !BYP);

        // Random traffic with a reset in the middle.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                fc = commit_q.size();
                do_reset();
                check_eq("midreset_occ", occupancy, 0);
                check_eq("midreset_wbrf", wbrf_valid, 1'b0);
            end
            random_cycle();
        end
        wbrf_ready  = 1'b1;
        wbpcg_ready = 1'b1;
        clear_inputs();
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
